// File: rtl/mcpu_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS-subset CPU: sequences each instruction,
// drives datapath enables/selects and the ALU-control aluop, and counts retirements.
//
//  state  | meaning
//  -------+-------------------------------------------------
//  FETCH  | request instruction, load IR and PC+4 on ready
//  DECODE | read regs, precompute branch target into ALUOut
//  MEMADR | compute lw/sw effective address
//  MEMRD  | data read, wait for ready
//  MEMWB  | write MDR to rt
//  MEMWR  | data write, wait for ready
//  REXE   | R-type ALU operation
//  RWB    | write ALUOut to rd
//  IEXE   | immediate ALU operation
//  IWB    | write ALUOut to rt
//  BRANCH | compare, load PC from ALUOut if taken
//  JUMP   | j/jal
//  JR     | jr/jalr
module mcpu_main_ctrl #(
   parameter int RET_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [4:0]       rt,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_en,
   output logic [1:0]       pc_source,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       aluop,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_sel,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXE   = 4'd6,  S_RWB   = 4'd7,
      S_IEXE   = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
      S_JR     = 4'd12
   } state_t;

   state_t state_q, state_n;
   logic   funct_ok;
   logic   retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         retired <= '0;
      end else begin
         state_q <= state_n;
         if (retire) retired <= retired + RET_W'(1);
      end
   end

   assign state = state_q;

   always_comb begin
      funct_ok = 1'b0;
      case (funct)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
         6'h2a, 6'h2b: funct_ok = 1'b1;
         default:      funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_n   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      pc_source = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      aluop     = 4'h0;
      reg_write = 1'b0;
      reg_dst   = 2'd0;
      wb_sel    = 2'd0;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_n  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'd3;
            state_n   = S_FETCH;
            case (opcode)
               6'h00: begin
                  if (!funct_ok)                          illegal = 1'b1;
                  else if (funct == 6'h08 || funct == 6'h09) state_n = S_JR;
                  else                                    state_n = S_REXE;
               end
               6'h01: begin
                  if (rt == 5'd0 || rt == 5'd1) state_n = S_BRANCH;
                  else                          illegal = 1'b1;
               end
               6'h02, 6'h03:                      state_n = S_JUMP;
               6'h04, 6'h05, 6'h06, 6'h07:        state_n = S_BRANCH;
               6'h08, 6'h09, 6'h0a, 6'h0b,
               6'h0c, 6'h0d, 6'h0e, 6'h0f:        state_n = S_IEXE;
               6'h23, 6'h2b:                      state_n = S_MEMADR;
               default:                           illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_n   = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_n = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write = 1'b1;
            wb_sel    = 2'd1;
            state_n   = S_FETCH;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_n = S_FETCH;
         end
         S_REXE: begin
            alu_src_a = 1'b1;
            aluop     = 4'h2;
            state_n   = S_RWB;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 2'd1;
            state_n   = S_FETCH;
         end
         S_IEXE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_n   = S_IWB;
            case (opcode)
               6'h08, 6'h09: aluop = 4'h3;
               6'h0a:        aluop = 4'h8;
               6'h0b:        aluop = 4'h9;
               6'h0c:        aluop = 4'h4;
               6'h0d:        aluop = 4'h5;
               6'h0e:        aluop = 4'h6;
               6'h0f:        aluop = 4'h7;
               default:      aluop = 4'h0;
            endcase
         end
         S_IWB: begin
            reg_write = 1'b1;
            state_n   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            pc_source = 2'd1;
            state_n   = S_FETCH;
            case (opcode)
               6'h04:   aluop = 4'h1;
               6'h05:   aluop = 4'hb;
               6'h06:   aluop = 4'hd;
               6'h07:   aluop = 4'hc;
               6'h01:   aluop = rt[0] ? 4'hf : 4'he;
               default: aluop = 4'h0;
            endcase
            // bne and bgez are the only inverted-sense branches
            if (opcode == 6'h05 || (opcode == 6'h01 && rt[0])) pc_en = !alu_zero;
            else                                              pc_en = alu_zero;
         end
         S_JUMP: begin
            pc_en     = 1'b1;
            pc_source = 2'd2;
            state_n   = S_FETCH;
            if (opcode == 6'h03) begin
               reg_write = 1'b1;
               reg_dst   = 2'd2;
               wb_sel    = 2'd2;
            end
         end
         S_JR: begin
            pc_en     = 1'b1;
            pc_source = 2'd3;
            state_n   = S_FETCH;
            if (funct == 6'h09) begin
               reg_write = 1'b1;
               reg_dst   = 2'd1;
               wb_sel    = 2'd2;
            end
         end
         default: begin
            illegal = 1'b1;
            state_n = S_FETCH;
         end
      endcase

      retire = (state_q != S_FETCH) && (state_n == S_FETCH) && !illegal;

      // Reset must kill an in-flight request without waiting for a clock
      if (!rst_n) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         iord      = 1'b0;
         ir_write  = 1'b0;
         pc_en     = 1'b0;
         pc_source = 2'd0;
         alu_src_a = 1'b0;
         alu_src_b = 2'd0;
         aluop     = 4'h0;
         reg_write = 1'b0;
         reg_dst   = 2'd0;
         wb_sel    = 2'd0;
         illegal   = 1'b0;
      end
   end

endmodule

// File: doc/mcpu_main_ctrl.md
# mcpu_main_ctrl

Main control state machine for the multi-cycle MIPS-subset CPU. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, and supplies the 4-bit `aluop` consumed by the ALU control decoder. It also stalls on a shared instruction/data memory through a request/ready handshake and counts retired instructions.

## Interface
Parameters:
- `RET_W`, 32, width of the retired-instruction counter

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `rt`  in  5  IR[20:16]; selects bltz/bgez for opcode 0x01
- `alu_zero`  in  1  ALU condition flag: 1 = compare true / result zero
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory access request, held until `mem_ready`
- `mem_we`  out  1  write qualifier for `mem_req`
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load IR
- `pc_en`  out  1  load PC
- `pc_source`  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target, 3 = rs
- `alu_src_a`  out  1  0 = PC, 1 = rs
- `alu_src_b`  out  2  0 = rt, 1 = constant 4, 2 = extended imm, 3 = imm<<2
- `aluop`  out  4  to ALU control decoder
- `reg_write`  out  1  register file write
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = $31
- `wb_sel`  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- `illegal`  out  1  one-cycle pulse on an undecodable instruction
- `state`  out  4  current state, debug
- `retired`  out  RET_W  retired-instruction count, wraps

## Operation
- **aluop encoding:**
  - 0 = address/PC add (lw, sw, fetch, decode)
  - 1 = beq
  - 2 = R-type
  - 3 = addi/addiu
  - 4 = andi
  - 5 = ori
  - 6 = xori
  - 7 = lui
  - 8 = slti
  - 9 = sltiu
  - b = bne
  - c = bgtz
  - d = blez
  - e = bltz
  - f = bgez
- **Legal opcodes:** 00, 01 (rt 0/1 only), 02–0f, 23, 2b.
- **Legal funct:** 00, 02, 03, 04, 06, 07, 08, 09, 20–27, 2a, 2b.
- **States** (encoding in parentheses). Outputs not listed are 0.
  - FETCH(0): `mem_req`, src_a=0, src_b=1, aluop=0. When `mem_ready` is high, also assert `ir_write` and `pc_en` (pc_source=0) and go to DECODE; otherwise hold.
  - DECODE(1): src_a=0, src_b=3, aluop=0 (branch target computed into ALUOut). Next state:
    - lw/sw → MEMADR
    - R-type with funct 08/09 → JR
    - other R-type → REXE
    - 08–0f → IEXE
    - 01, 04–07 → BRANCH
    - 02/03 → JUMP
    - illegal → pulse `illegal`, return to FETCH, no retire
  - MEMADR(2): src_a=1, src_b=2, aluop=0. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): `mem_req`, iord=1. Hold until `mem_ready`, then go to MEMWB.
  - MEMWB(4): `reg_write`, reg_dst=0, wb_sel=1. Go to FETCH.
  - MEMWR(5): `mem_req`, `mem_we`, iord=1. Hold until `mem_ready`, then go to FETCH.
  - REXE(6): src_a=1, src_b=0, aluop=2. Go to RWB.
  - RWB(7): `reg_write`, reg_dst=1, wb_sel=0. Go to FETCH.
  - IEXE(8): src_a=1, src_b=2, aluop per opcode. Go to IWB.
  - IWB(9): `reg_write`, reg_dst=0, wb_sel=0. Go to FETCH.
  - BRANCH(10): src_a=1, src_b=0, pc_source=1, aluop per opcode/rt. `pc_en` = taken, where taken = `alu_zero`, except bne and bgez where taken = !`alu_zero`. Go to FETCH.
  - JUMP(11): `pc_en`, pc_source=2. For jal, also `reg_write`, reg_dst=2, wb_sel=2. Go to FETCH.
  - JR(12): `pc_en`, pc_source=3. For jalr, also `reg_write`, reg_dst=1, wb_sel=2. Go to FETCH.
  - Codes 13–15 are unreachable. If entered, go to FETCH with `illegal` asserted for one cycle.
- `retired` increments by 1 in the final cycle of each legal instruction (the cycle whose next state is FETCH, excluding illegal). It wraps from all-ones to 0.
- All outputs except `state` and `retired` are Moore decodes of state, plus opcode/funct/rt/`mem_ready` where noted above.

## Timing
- **Reset:**
  - While `rst_n` is low: state=FETCH, `retired`=0, all control outputs forced to 0 (including `mem_req`).
  - The first request is issued in the first cycle after release.
  - Reset asserted mid-access drops `mem_req` immediately; memory abandons the access.
- **Cycles with zero-wait memory:**
  - lw: 5
  - sw, R-type, I-type: 4
  - branch, j/jal, jr/jalr: 3
  - illegal: 2
- **Memory wait:** each wait cycle in FETCH, MEMRD or MEMWR adds one cycle. During waits, all outputs stay stable and `ir_write`/`pc_en` remain 0.
- **Handshake:** a transfer completes on a cycle with `mem_req` && `mem_ready`. `mem_ready` without `mem_req` is ignored.
- **Register writes:** IR and PC update on the FETCH completion edge. Register file writes occur on the exit edge of the write-back state.

## Test plan
- Reset, then add $3,$1,$2 with `mem_ready` tied 1: state sequence 0,1,6,7,0. In state 6, aluop=2. In state 7, `reg_write`=1, reg_dst=1. `retired` goes 0→1.
- lw with `mem_ready` low for 3 cycles in MEMRD: sequence 0,1,2,3,3,3,3,4,0 (3 wait cycles plus the completion cycle, 8 cycles total). `mem_req`=1 and iord=1 throughout state 3. `wb_sel`=1 in state 4.
- beq with `alu_zero`=1: `pc_en`=1, pc_source=1 in BRANCH. bne with `alu_zero`=1: `pc_en`=0. Opcode 01, rt=1 (bgez), `alu_zero`=0: taken, aluop=f.
- jal: JUMP asserts `pc_en`, pc_source=2, `reg_write`, reg_dst=2, wb_sel=2. jalr: JR asserts pc_source=3, reg_dst=1.
- Opcode 0x3f, then R-type funct 0x01: `illegal` pulses once in DECODE, returns to FETCH, `retired` unchanged.
- Reset asserted in MEMWR with `mem_req` high: `mem_req` drops asynchronously, state=0, `retired`=0. Preload `retired`=all-ones and retire once: `retired`=0.
